freq_sweep_ctrl: RTL and testbench

Sequences the frequency word that feeds the phase accumulator (NCO), producing linear frequency sweeps (chirps).
- Sweep is defined by start, stop, step, per-step dwell (in clock cycles) and sweep mode.
- When no sweep is running, the block passes a static manual frequency to the accumulator.
- Sits between the control/register front end and the accumulator's freq_word input.

---
 rtl/freq_sweep_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_freq_sweep_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// freq_sweep_ctrl
//
// Purpose:
//   Drives the frequency word for the phase accumulator. While idle, the
//   static manual frequency is passed through with one cycle of latency.
//   On a start request, a linear sweep (chirp) from start to stop is run.
//   Each frequency is held for a dwell of D cycles. Single, repeating
//   (sawtooth) and triangle sweeps are supported.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   manual_freq     - frequency driven while idle
//   cfg_start_freq  - sweep start frequency
//   cfg_stop_freq   - sweep stop frequency
//   cfg_step        - step magnitude (0 is rejected, raising cfg_err)
//   cfg_dwell       - cycles per frequency (0 treated as 1)
//   cfg_mode        - 00 single, 01 repeat, 10 triangle, 11 single
//   start           - one-cycle sweep request (ignored while sweeping)
//   abort           - stop the sweep at the next edge (highest priority)
//   freq_word       - frequency word to the accumulator
//   sweep_active    - high while sweeping
//   step_stb        - pulse on every sweep-driven freq_word change
//   done            - pulse at the end of a single sweep
//   cfg_err         - sticky illegal-step flag, cleared by an accepted start
// ---------------------------------------------------------------------------
module freq_sweep_ctrl #(
  parameter int FREQ_W  = 20,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [FREQ_W-1:0]  manual_freq,
  input  logic [FREQ_W-1:0]  cfg_start_freq,
  input  logic [FREQ_W-1:0]  cfg_stop_freq,
  input  logic [FREQ_W-1:0]  cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [1:0]         cfg_mode,
  input  logic               start,
  input  logic               abort,
  output logic [FREQ_W-1:0]  freq_word,
  output logic               sweep_active,
  output logic               step_stb,
  output logic               done,
  output logic               cfg_err
);

  typedef enum logic [0:0] {IDLE, SWEEP} state_t;

  localparam logic [1:0] MODE_REPEAT   = 2'b01;
  localparam logic [1:0] MODE_TRIANGLE = 2'b10;

  state_t             state_reg,      state_next;
  logic [FREQ_W-1:0]  freq_word_reg,  freq_word_next;
  logic               active_reg,     active_next;
  logic               step_stb_reg,   step_stb_next;
  logic               done_reg,       done_next;
  logic               cfg_err_reg,    cfg_err_next;
  logic [DWELL_W-1:0] dwell_cnt_reg,  dwell_cnt_next;
  logic [DWELL_W-1:0] dwell_rl_reg,   dwell_rl_next;   // D-1, reload value
  logic [FREQ_W-1:0]  origin_reg,     origin_next;     // endpoint we left from
  logic [FREQ_W-1:0]  target_reg,     target_next;     // endpoint we head to
  logic [FREQ_W-1:0]  step_reg,       step_next;
  logic [1:0]         mode_reg,       mode_next;
  logic               dir_up_reg,     dir_up_next;

  // One step from cur toward tgt. Arithmetic is one bit wider so that both
  // overshoot above the target and underflow below zero are caught and
  // clamped to the target instead of wrapping.
  function automatic logic [FREQ_W-1:0] step_toward(
    input logic [FREQ_W-1:0] cur,
    input logic [FREQ_W-1:0] stp,
    input logic [FREQ_W-1:0] tgt,
    input logic              up
  );
    logic [FREQ_W:0] wide;
    logic [FREQ_W-1:0] res;
    if (up) begin
      wide = {1'b0, cur} + {1'b0, stp};
      res  = (wide > {1'b0, tgt}) ? tgt : wide[FREQ_W-1:0];
    end else begin
      wide = {1'b0, cur} - {1'b0, stp};
      res  = (wide[FREQ_W] || (wide[FREQ_W-1:0] < tgt)) ? tgt : wide[FREQ_W-1:0];
    end
    return res;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      freq_word_reg <= '0;
      active_reg    <= 1'b0;
      step_stb_reg  <= 1'b0;
      done_reg      <= 1'b0;
      cfg_err_reg   <= 1'b0;
      dwell_cnt_reg <= '0;
      dwell_rl_reg  <= '0;
      origin_reg    <= '0;
      target_reg    <= '0;
      step_reg      <= '0;
      mode_reg      <= 2'b00;
      dir_up_reg    <= 1'b1;
    end else begin
      state_reg     <= state_next;
      freq_word_reg <= freq_word_next;
      active_reg    <= active_next;
      step_stb_reg  <= step_stb_next;
      done_reg      <= done_next;
      cfg_err_reg   <= cfg_err_next;
      dwell_cnt_reg <= dwell_cnt_next;
      dwell_rl_reg  <= dwell_rl_next;
      origin_reg    <= origin_next;
      target_reg    <= target_next;
      step_reg      <= step_next;
      mode_reg      <= mode_next;
      dir_up_reg    <= dir_up_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    freq_word_next = freq_word_reg;
    active_next    = active_reg;
    step_stb_next  = 1'b0;
    done_next      = 1'b0;
    cfg_err_next   = cfg_err_reg;
    dwell_cnt_next = dwell_cnt_reg;
    dwell_rl_next  = dwell_rl_reg;
    origin_next    = origin_reg;
    target_next    = target_reg;
    step_next      = step_reg;
    mode_next      = mode_reg;
    dir_up_next    = dir_up_reg;

    unique case (state_reg)
      IDLE: begin
        freq_word_next = manual_freq;
        active_next    = 1'b0;
        dwell_cnt_next = '0;
        if (start && !abort) begin
          if (cfg_step == '0) begin
            cfg_err_next = 1'b1;
          end else begin
            state_next     = SWEEP;
            freq_word_next = cfg_start_freq;
            active_next    = 1'b1;
            step_stb_next  = 1'b1;
            cfg_err_next   = 1'b0;
            origin_next    = cfg_start_freq;
            target_next    = cfg_stop_freq;
            step_next      = cfg_step;
            mode_next      = cfg_mode;
            dir_up_next    = (cfg_start_freq <= cfg_stop_freq);
            dwell_rl_next  = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
            dwell_cnt_next = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
          end
        end
      end

      SWEEP: begin
        if (abort) begin
          state_next     = IDLE;
          freq_word_next = manual_freq;
          active_next    = 1'b0;
          dwell_cnt_next = '0;
        end else if (dwell_cnt_reg != '0) begin
          dwell_cnt_next = dwell_cnt_reg - DWELL_W'(1);
        end else if (freq_word_reg != target_reg) begin
          freq_word_next = step_toward(freq_word_reg, step_reg, target_reg, dir_up_reg);
          step_stb_next  = 1'b1;
          dwell_cnt_next = dwell_rl_reg;
        end else if (mode_reg == MODE_REPEAT) begin
          // Sawtooth: origin is never swapped, so it is still the start.
          freq_word_next = origin_reg;
          step_stb_next  = 1'b1;
          dwell_cnt_next = dwell_rl_reg;
        end else if (mode_reg == MODE_TRIANGLE) begin
          // Reverse: the reached endpoint becomes the origin and the first
          // step of the new leg is taken on this same edge.
          target_next    = origin_reg;
          origin_next    = target_reg;
          dir_up_next    = ~dir_up_reg;
          freq_word_next = step_toward(freq_word_reg, step_reg, origin_reg, ~dir_up_reg);
          step_stb_next  = 1'b1;
          dwell_cnt_next = dwell_rl_reg;
        end else begin
          state_next     = IDLE;
          freq_word_next = manual_freq;
          active_next    = 1'b0;
          done_next      = 1'b1;
          dwell_cnt_next = '0;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign freq_word    = freq_word_reg;
  assign sweep_active = active_reg;
  assign step_stb     = step_stb_reg;
  assign done         = done_reg;
  assign cfg_err      = cfg_err_reg;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_freq_sweep_ctrl
//
// Directed testbench for freq_sweep_ctrl. The stimulus sequence pushes the
// expected output of every clock cycle into a queue. A monitor on the
// falling edge pops each entry and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_freq_sweep_ctrl;

  localparam int FREQ_W  = 20;
  localparam int DWELL_W = 24;

  typedef struct packed {
    logic [FREQ_W-1:0] fw;
    logic              act;
    logic              stb;
    logic              dn;
    logic              err;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [FREQ_W-1:0]  manual_freq = '0;
  logic [FREQ_W-1:0]  cfg_start_freq = '0;
  logic [FREQ_W-1:0]  cfg_stop_freq = '0;
  logic [FREQ_W-1:0]  cfg_step = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [1:0]         cfg_mode = 2'b00;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [FREQ_W-1:0]  freq_word;
  logic               sweep_active;
  logic               step_stb;
  logic               done;
  logic               cfg_err;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc_no = 0;
  logic exp_err = 1'b0;
  exp_t exp_q[$];
  int   tag_q[$];

  freq_sweep_ctrl #(.FREQ_W(FREQ_W), .DWELL_W(DWELL_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .manual_freq    (manual_freq),
    .cfg_start_freq (cfg_start_freq),
    .cfg_stop_freq  (cfg_stop_freq),
    .cfg_step       (cfg_step),
    .cfg_dwell      (cfg_dwell),
    .cfg_mode       (cfg_mode),
    .start          (start),
    .abort          (abort),
    .freq_word      (freq_word),
    .sweep_active   (sweep_active),
    .step_stb       (step_stb),
    .done           (done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: one line per compared transaction.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t g;
      int   t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      g = '{fw: freq_word, act: sweep_active, stb: step_stb, dn: done, err: cfg_err};
      n_cmp++;
      assert (g === e) else begin
        n_fail++;
        $error("FAIL cyc%0d observed fw=%0d act=%b stb=%b done=%b err=%b expected fw=%0d act=%b stb=%b done=%b err=%b",
               t, g.fw, g.act, g.stb, g.dn, g.err, e.fw, e.act, e.stb, e.dn, e.err);
      end
      $display("cyc%0d fw=%0d act=%b stb=%b done=%b err=%b", t, g.fw, g.act, g.stb, g.dn, g.err);
    end
  end

  // Advance one clock and push what the outputs must be after that edge.
  task automatic tick(input logic [FREQ_W-1:0] fw, input logic act, input logic stb, input logic dn);
    @(posedge clk);
    #1;
    cyc_no++;
    exp_q.push_back('{fw: fw, act: act, stb: stb, dn: dn, err: exp_err});
    tag_q.push_back(cyc_no);
  endtask

  // Hold a sweep value for n further cycles (no strobe).
  task automatic hold(input logic [FREQ_W-1:0] fw, input int n);
    for (int i = 0; i < n; i++) tick(fw, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic cfg(input int s, input int p, input int st, input int dw, input logic [1:0] m);
    cfg_start_freq = FREQ_W'(s);
    cfg_stop_freq  = FREQ_W'(p);
    cfg_step       = FREQ_W'(st);
    cfg_dwell      = DWELL_W'(dw);
    cfg_mode       = m;
  endtask

  initial begin
    // ---- reset state ----
    manual_freq = 20'd500;
    #12;
    n_cmp++;
    assert ({freq_word, sweep_active, step_stb, done, cfg_err} === {20'd0, 4'b0000}) else begin
      n_fail++;
      $error("FAIL reset observed fw=%0d act=%b stb=%b done=%b err=%b expected all 0",
             freq_word, sweep_active, step_stb, done, cfg_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(500, 0, 0, 0);
    manual_freq = 20'd600;
    tick(600, 0, 0, 0);
    manual_freq = 20'd500;
    tick(500, 0, 0, 0);

    // ---- single up: 1000,1004,1008,1010 each 3 cycles, then done ----
    cfg(1000, 1010, 4, 3, 2'b00);
    start = 1'b1;
    tick(1000, 1, 1, 0);
    start = 1'b0;
    hold(1000, 2);
    tick(1004, 1, 1, 0); hold(1004, 2);
    tick(1008, 1, 1, 0); hold(1008, 2);
    tick(1010, 1, 1, 0); hold(1010, 2);
    tick(500, 0, 0, 1);
    tick(500, 0, 0, 0);

    // ---- single down with underflow clamp: 5,1,0 ----
    cfg(5, 0, 4, 1, 2'b00);
    start = 1'b1;
    tick(5, 1, 1, 0);
    start = 1'b0;
    tick(1, 1, 1, 0);
    tick(0, 1, 1, 0);
    tick(500, 0, 0, 1);
    tick(500, 0, 0, 0);

    // ---- triangle 100..108 step 4 dwell 2, mid-sweep start ignored ----
    cfg(100, 108, 4, 2, 2'b10);
    start = 1'b1;
    tick(100, 1, 1, 0);
    start = 1'b0;
    cfg(7000, 9000, 1, 9, 2'b00);   // must not affect the running sweep
    hold(100, 1);
    tick(104, 1, 1, 0); hold(104, 1);
    start = 1'b1;
    tick(108, 1, 1, 0);
    start = 1'b0;
    hold(108, 1);
    tick(104, 1, 1, 0); hold(104, 1);
    tick(100, 1, 1, 0); hold(100, 1);
    tick(104, 1, 1, 0); hold(104, 1);
    tick(108, 1, 1, 0);
    abort = 1'b1;
    tick(500, 0, 0, 0);
    abort = 1'b0;
    tick(500, 0, 0, 0);

    // ---- repeat 0..8 step 8 dwell 0, abort with simultaneous start ----
    cfg(0, 8, 8, 0, 2'b01);
    start = 1'b1;
    tick(0, 1, 1, 0);
    start = 1'b0;
    tick(8, 1, 1, 0);
    tick(0, 1, 1, 0);
    tick(8, 1, 1, 0);
    manual_freq = 20'd321;
    abort = 1'b1;
    start = 1'b1;
    tick(321, 0, 0, 0);
    abort = 1'b0;
    start = 1'b0;
    tick(321, 0, 0, 0);
    tick(321, 0, 0, 0);

    // ---- cfg_err on zero step, cleared by next valid start ----
    cfg(50, 50, 0, 2, 2'b00);
    start = 1'b1;
    exp_err = 1'b1;
    tick(321, 0, 0, 0);
    start = 1'b0;
    tick(321, 0, 0, 0);
    // start == stop single: one dwell then done
    cfg(50, 50, 3, 2, 2'b00);
    start = 1'b1;
    exp_err = 1'b0;
    tick(50, 1, 1, 0);
    start = 1'b0;
    hold(50, 1);
    tick(321, 0, 0, 1);

    // ---- start == stop in repeat: hold value, strobe every D cycles ----
    cfg(77, 77, 5, 2, 2'b01);
    start = 1'b1;
    tick(77, 1, 1, 0);
    start = 1'b0;
    hold(77, 1);
    tick(77, 1, 1, 0); hold(77, 1);
    tick(77, 1, 1, 0);
    abort = 1'b1;
    tick(321, 0, 0, 0);
    abort = 1'b0;

    // ---- reset mid-dwell ----
    cfg(1000, 1010, 4, 3, 2'b00);
    start = 1'b1;
    tick(1000, 1, 1, 0);
    start = 1'b0;
    hold(1000, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    assert ({freq_word, sweep_active, step_stb, done, cfg_err} === {20'd0, 4'b0000}) else begin
      n_fail++;
      $error("FAIL async_reset observed fw=%0d act=%b stb=%b done=%b err=%b expected all 0",
             freq_word, sweep_active, step_stb, done, cfg_err);
    end
    manual_freq = 20'd444;
    @(negedge clk);
    rst_n = 1'b1;
    tick(444, 0, 0, 0);
    tick(444, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_cmp++;
    assert (exp_q.size() == 0) else begin
      n_fail++;
      $error("FAIL drain observed %0d pending expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
